fifo_pop_demux: RTL and testbench

Downstream consumer of the 4-bit TLP word FIFO. It pops words whenever the FIFO is non-empty and neither destination can overflow, then steers each word to one of two downstream FIFOs by its MSB (class bit). It throttles on downstream `almost_full`, and latches a sticky fault when the upstream FIFO reports `error`. It sits between the ingress word FIFO and the two per-class FIFOs.

---
 rtl/tlp_pkg.sv | 26 ++
 rtl/fpd_route.sv | 59 +++++
 rtl/fifo_pop_demux.sv | 114 +++++++++++
 tb/tb_fifo_pop_demux.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlp_pkg.sv
// ============================================================================
// Module   : tlp_pkg
// Purpose  : Shared TLP word-path types, defaults and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tlp_pkg;

    localparam int TLP_DATA_W = 4;

    localparam logic [1:0] FPD_IDLE   = 2'd0;
    localparam logic [1:0] FPD_ACTIVE = 2'd1;
    localparam logic [1:0] FPD_STALL  = 2'd2;
    localparam logic [1:0] FPD_FAULT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = FPD_IDLE,
        ST_ACTIVE = FPD_ACTIVE,
        ST_STALL  = FPD_STALL,
        ST_FAULT  = FPD_FAULT
    } fpd_state_t;

endpackage

`default_nettype wire

// File: rtl/fpd_route.sv
// ============================================================================
// Module   : fpd_route
// Purpose  : Delays the pop strobe one cycle and steers the returned word to
//            the class-0 or class-1 output register by its MSB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpd_route
    import tlp_pkg::*;
#(
    parameter int DATA_W = TLP_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pop,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              dest0_push,
    output logic [DATA_W-1:0] dest0_data,
    output logic              dest1_push,
    output logic [DATA_W-1:0] dest1_data
);

    logic              r_pop_d;
    logic              r_push0;
    logic              r_push1;
    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic              w_class;

    assign w_class = fifo_data[DATA_W-1];

    // fifo_data is only meaningful while r_pop_d is high (q_b lags the pop).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pop_d <= 1'b0;
            r_push0 <= 1'b0;
            r_push1 <= 1'b0;
            r_data0 <= '0;
            r_data1 <= '0;
        end else begin
            r_pop_d <= pop;
            r_push0 <= r_pop_d & ~w_class;
            r_push1 <= r_pop_d &  w_class;
            if (r_pop_d && !w_class)
                r_data0 <= fifo_data;
            if (r_pop_d && w_class)
                r_data1 <= fifo_data;
        end
    end

    assign dest0_push = r_push0;
    assign dest0_data = r_data0;
    assign dest1_push = r_push1;
    assign dest1_data = r_data1;

endmodule

`default_nettype wire

// File: rtl/fifo_pop_demux.sv
// ============================================================================
// Module   : fifo_pop_demux
// Purpose  : Pops the ingress word FIFO and demuxes words to two class FIFOs,
//            throttling on either almost_full; sticky fault on fifo_error.
//            Optional per-class forwarded counters: define FPD_COUNTERS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_pop_demux
    import tlp_pkg::*;
#(
    parameter int DATA_W = TLP_DATA_W
`ifdef FPD_COUNTERS_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    input  logic              fifo_error,
    input  logic              dest0_almost_full,
    input  logic              dest1_almost_full,
    output logic              fifo_pop,
    output logic              dest0_push,
    output logic [DATA_W-1:0] dest0_data,
    output logic              dest1_push,
    output logic [DATA_W-1:0] dest1_data,
    output logic              fault
`ifdef FPD_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]  dest0_count,
    output logic [CNT_W-1:0]  dest1_count
`endif
);

    fpd_state_t r_state;
    fpd_state_t w_state_next;
    logic       w_can_pop;
    logic       w_pop;
    logic       w_push0;
    logic       w_push1;

    // Both almost_full flags gate popping: the class is unknown until q_b returns.
    assign w_can_pop = (r_state != ST_FAULT) & ~fifo_empty
                     & ~dest0_almost_full & ~dest1_almost_full;
    // An error in the same cycle wins over popping; reset forces the strobe low.
    assign w_pop     = w_can_pop & ~fifo_error & reset;
    assign fifo_pop  = w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (fifo_error)
            w_state_next = ST_FAULT;
        else if (r_state == ST_FAULT)
            w_state_next = ST_FAULT;
        else if (w_can_pop)
            w_state_next = ST_ACTIVE;
        else if (fifo_empty)
            w_state_next = ST_IDLE;
        else
            w_state_next = ST_STALL;
    end

    assign fault = (r_state == ST_FAULT);

    fpd_route #(
        .DATA_W     (DATA_W)
    ) u_route (
        .clk        (clk),
        .reset      (reset),
        .pop        (w_pop),
        .fifo_data  (fifo_data),
        .dest0_push (w_push0),
        .dest0_data (dest0_data),
        .dest1_push (w_push1),
        .dest1_data (dest1_data)
    );

    assign dest0_push = w_push0;
    assign dest1_push = w_push1;

`ifdef FPD_COUNTERS_EN
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_push0)
                r_cnt0 <= r_cnt0 + 1'b1;
            if (w_push1)
                r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign dest0_count = r_cnt0;
    assign dest1_count = r_cnt1;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_pop_demux.sv
// ============================================================================
// Module   : tb_fifo_pop_demux
// Purpose  : Randomized scoreboard bench for fifo_pop_demux with a queue-based
//            upstream FIFO model. Counter checks built when FPD_COUNTERS_EN set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_pop_demux;
    import tlp_pkg::*;

    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_error = 1'b0;
    logic          dest0_almost_full = 1'b0;
    logic          dest1_almost_full = 1'b0;
    logic          fifo_pop;
    logic          dest0_push;
    logic [DW-1:0] dest0_data;
    logic          dest1_push;
    logic [DW-1:0] dest1_data;
    logic          fault;
`ifdef FPD_COUNTERS_EN
    logic [7:0]    dest0_count;
    logic [7:0]    dest1_count;
`endif

    fifo_pop_demux dut (
        .clk               (clk),
        .reset             (reset),
        .fifo_data         (fifo_data),
        .fifo_empty        (fifo_empty),
        .fifo_error        (fifo_error),
        .dest0_almost_full (dest0_almost_full),
        .dest1_almost_full (dest1_almost_full),
        .fifo_pop          (fifo_pop),
        .dest0_push        (dest0_push),
        .dest0_data        (dest0_data),
        .dest1_push        (dest1_push),
        .dest1_data        (dest1_data),
        .fault             (fault)
`ifdef FPD_COUNTERS_EN
        ,
        .dest0_count       (dest0_count),
        .dest1_count       (dest1_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] w;
        int            due;
    } exp_t;

    logic [DW-1:0] up_q[$];
    exp_t          sb[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    // Reference model state
    logic          m_fault = 1'b0;
    logic [1:0]    m_state = FPD_IDLE;
    logic [DW-1:0] m_d0 = '0;
    logic [DW-1:0] m_d1 = '0;
    logic [7:0]    m_cnt0 = '0;
    logic [7:0]    m_cnt1 = '0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard when an entry falls due and compares outputs.
    always @(negedge clk) begin
        logic e0;
        logic e1;
        exp_t e;
        e0 = 1'b0;
        e1 = 1'b0;
        if (reset) begin
            while (sb.size() != 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                check("stale_entry", 32'(e.due), 32'(cyc));
            end
            if (sb.size() != 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (e.w[DW-1]) begin
                    e1 = 1'b1;
                    m_d1 = e.w;
                    m_cnt1 = m_cnt1 + 8'd1;
                end else begin
                    e0 = 1'b1;
                    m_d0 = e.w;
                    m_cnt0 = m_cnt0 + 8'd1;
                end
            end
        end
        check("dest0_push", 32'(dest0_push), 32'(e0));
        check("dest1_push", 32'(dest1_push), 32'(e1));
        check("dest0_data", 32'(dest0_data), 32'(m_d0));
        check("dest1_data", 32'(dest1_data), 32'(m_d1));
        check("fault", 32'(fault), 32'(m_fault));
`ifdef FPD_COUNTERS_EN
        check("dest0_count", 32'(dest0_count), 32'(m_cnt0));
        check("dest1_count", 32'(dest1_count), 32'(m_cnt1));
`endif
    end

    // One clock of normal operation; starts and ends just after a rising edge.
    task automatic cycle(input bit af0, input bit af1, input bit err);
        logic       exp_pop;
        logic [1:0] nst;
        dest0_almost_full = af0;
        dest1_almost_full = af1;
        fifo_error        = err;
        fifo_empty        = (up_q.size() == 0);
        #2;
        exp_pop = !m_fault && (up_q.size() != 0) && !af0 && !af1 && !err;
        check("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
        if (err || m_fault)
            nst = FPD_FAULT;
        else if (up_q.size() != 0 && !af0 && !af1)
            nst = FPD_ACTIVE;
        else if (up_q.size() == 0)
            nst = FPD_IDLE;
        else
            nst = FPD_STALL;
        @(posedge clk);
        #1;
        if (exp_pop) begin
            fifo_data = up_q.pop_front();
            sb.push_back('{w: fifo_data, due: cyc + 1});
        end
        fifo_empty = (up_q.size() == 0);
        if (err)
            m_fault = 1'b1;
        m_state = nst;
        check("state", 32'(dut.r_state), 32'(m_state));
    endtask

    // Hold reset low for n clocks with all inputs toggling, then release.
    task automatic apply_reset(input int n);
        reset = 1'b0;
        sb.delete();
        up_q.delete();
        m_fault = 1'b0;
        m_state = FPD_IDLE;
        m_d0    = '0;
        m_d1    = '0;
        m_cnt0  = '0;
        m_cnt1  = '0;
        for (int i = 0; i < n; i++) begin
            fifo_data         = 4'($urandom_range(0, 15));
            fifo_empty        = 1'($urandom_range(0, 1));
            fifo_error        = 1'($urandom_range(0, 1));
            dest0_almost_full = 1'($urandom_range(0, 1));
            dest1_almost_full = 1'($urandom_range(0, 1));
            #2;
            check("pop_in_reset", 32'(fifo_pop), 32'd0);
            check("state_in_reset", 32'(dut.r_state), 32'(FPD_IDLE));
            @(posedge clk);
            #1;
        end
        fifo_error        = 1'b0;
        dest0_almost_full = 1'b0;
        dest1_almost_full = 1'b0;
        fifo_empty        = 1'b1;
        reset             = 1'b1;
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles && up_q.size() != 0; i++)
            cycle(1'b0, 1'b0, 1'b0);
        check("upstream_drained", 32'(up_q.size()), 32'd0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset with toggling inputs, then idle while empty
        apply_reset(4);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b0);

        // Directed burst of four alternating-class words
        up_q = '{4'h1, 4'h9, 4'h3, 4'hA};
        for (int i = 0; i < 6; i++)
            cycle(1'b0, 1'b0, 1'b0);

        // dest1 almost_full for three cycles mid-burst
        for (int i = 0; i < 8; i++)
            up_q.push_back(4'($urandom_range(0, 15)));
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b1, 1'b0);
        drain(20);

        // Random traffic with random backpressure on either side
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0 && up_q.size() < 6)
                up_q.push_back(4'($urandom_range(0, 15)));
            cycle(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0), 1'b0);
        end
        drain(20);

        // Reset asserted the cycle after a pop drops the in-flight word
        up_q = '{4'h6, 4'hC, 4'h2};
        cycle(1'b0, 1'b0, 1'b0);
        apply_reset(2);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 1'b0, 1'b0);

        // Error one cycle after popping 0x5: push completes, then sticky fault
        up_q = '{4'h5};
        cycle(1'b0, 1'b0, 1'b0);
        up_q = '{4'h2, 4'hB, 4'h4};
        cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, 1'b0);
        apply_reset(2);
        for (int i = 0; i < 2; i++)
            cycle(1'b0, 1'b0, 1'b0);

`ifdef FPD_COUNTERS_EN
        // 257 class-1 words wrap dest1_count to 1
        for (int i = 0; i < 257; i++)
            up_q.push_back({1'b1, 3'($urandom_range(0, 7))});
        drain(300);
        check("dest1_count_wrap", 32'(dest1_count), 32'd1);
        check("dest0_count_zero", 32'(dest0_count), 32'd0);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
